// File: rtl/core_pkg.sv
// Shared core definitions: opcode encodings, instruction field positions,
// bubble encoding and opcode classification helpers.
package core_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 32;
  localparam int NREGS   = 32;
  localparam int IDX_W   = 5;
  localparam int OPC_W   = 5;
  localparam int IMM_W   = 7;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 17;
  localparam int RS2_HI = 16;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 6;
  localparam int IMM_LO = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_ADDI = 5'd6,
    OP_LD   = 5'd7,
    OP_ST   = 5'd8,
    OP_BEQ  = 5'd9,
    OP_BGT  = 5'd10,
    OP_BLT  = 5'd11,
    OP_JMP  = 5'd12,
    OP_CMP  = 5'd13
  } opcode_e;

  localparam logic [OPC_W-1:0] NOP_CTRL = 5'd0;

  // Opcodes ADD..LD write a destination register
  function automatic logic is_writer(input logic [OPC_W-1:0] op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LD: w = 1'b1;
      default:                                              w = 1'b0;
    endcase
    return w;
  endfunction

  // Opcodes 14..31 have no defined meaning
  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x16 register file: async clear, two combinational read ports with
// write-first bypass from the writeback port, r0 hard-wired to zero.
module decode_regfile
  import core_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREGS,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [IW-1:0] rd1_idx_i,
  input  logic [IW-1:0] rd2_idx_i,
  output logic [DW-1:0] rd1_data_o,
  output logic [DW-1:0] rd2_data_o
);

  logic [DW-1:0] mem_q [NR];

  // Storage: cleared on reset, written at the edge except for r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_idx_i != '0)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read port 1: r0 is zero, same-cycle write wins over stored value
  always_comb begin
    rd1_data_o = '0;
    if (rd1_idx_i == '0) begin
      rd1_data_o = '0;
    end else if (wr_en_i && (wr_idx_i == rd1_idx_i)) begin
      rd1_data_o = wr_data_i;
    end else begin
      rd1_data_o = mem_q[rd1_idx_i];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2_data_o = '0;
    if (rd2_idx_i == '0) begin
      rd2_data_o = '0;
    end else if (wr_en_i && (wr_idx_i == rd2_idx_i)) begin
      rd2_data_o = wr_data_i;
    end else begin
      rd2_data_o = mem_q[rd2_idx_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field slicing, register-file read, load-use stall detection,
// branch flush and the ID/EX pipeline register feeding Execute.
module decode_stage
  import core_pkg::*;
#(
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int INSTR_W = core_pkg::INSTR_W,
  parameter int NREGS   = core_pkg::NREGS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic [DATA_W-1:0]  npc_in,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [IDX_W-1:0]   wb_index,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               stall_out,
  output logic [OPC_W-1:0]   control_out,
  output logic [IDX_W-1:0]   dest_index_out,
  output logic [DATA_W-1:0]  reg1_data,
  output logic [DATA_W-1:0]  reg2_data,
  output logic [DATA_W-1:0]  npc_out,
  output logic [IMM_W-1:0]   immediate,
  output logic               valid_out
);

  // Decoded fields
  logic [OPC_W-1:0] opcode_s;
  logic [IDX_W-1:0] rd_s;
  logic [IDX_W-1:0] rs1_s;
  logic [IDX_W-1:0] rs2_s;
  logic [IMM_W-1:0] imm_s;
  logic             unused_s;

  assign opcode_s = instr_in[OPC_HI:OPC_LO];
  assign rd_s     = instr_in[RD_HI:RD_LO];
  assign rs1_s    = instr_in[RS1_HI:RS1_LO];
  assign rs2_s    = instr_in[RS2_HI:RS2_LO];
  assign imm_s    = instr_in[IMM_HI:IMM_LO];
  // Bits [11:7] carry no information for this core
  assign unused_s = ^instr_in[11:7];

  // Operand read
  logic [DATA_W-1:0] rs1_data_s;
  logic [DATA_W-1:0] rs2_data_s;

  decode_regfile #(
    .DW (DATA_W),
    .NR (NREGS),
    .IW (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wb_en),
    .wr_idx_i   (wb_index),
    .wr_data_i  (wb_data),
    .rd1_idx_i  (rs1_s),
    .rd2_idx_i  (rs2_s),
    .rd1_data_o (rs1_data_s),
    .rd2_data_o (rs2_data_s)
  );

  // ID/EX register state
  logic [OPC_W-1:0]  ctrl_q, ctrl_d;
  logic [IDX_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              valid_q, valid_d;
  logic              stall_s;

  // Load-use hazard: a load in ID/EX feeds an operand of the instr in decode;
  // a flush kills that instr, so it never stalls
  always_comb begin
    stall_s = 1'b0;
    if (flush) begin
      stall_s = 1'b0;
    end else if (valid_q && (ctrl_q == OP_LD) && (dest_q != '0) && instr_valid &&
                 ((rs1_s == dest_q) || (rs2_s == dest_q))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next ID/EX contents: bubble unless a legal, valid, unkilled instr is present
  always_comb begin
    ctrl_d  = NOP_CTRL;
    dest_d  = '0;
    r1_d    = '0;
    r2_d    = '0;
    npc_d   = '0;
    imm_d   = '0;
    valid_d = 1'b0;
    if (flush || stall_s || !instr_valid) begin
      valid_d = 1'b0;
    end else if (!is_legal(opcode_s)) begin
      valid_d = 1'b0;
    end else begin
      ctrl_d  = opcode_s;
      dest_d  = is_writer(opcode_s) ? rd_s : 5'd0;
      r1_d    = rs1_data_s;
      r2_d    = rs2_data_s;
      npc_d   = npc_in;
      imm_d   = imm_s;
      valid_d = 1'b1;
    end
  end

  // ID/EX pipeline register with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= NOP_CTRL;
      dest_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      npc_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      npc_q   <= npc_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign stall_out      = stall_s;
  assign control_out    = ctrl_q;
  assign dest_index_out = dest_q;
  assign reg1_data      = r1_q;
  assign reg2_data      = r2_q;
  assign npc_out        = npc_q;
  assign immediate      = imm_q;
  assign valid_out      = valid_q;

endmodule
